// File: rtl/laser_fire_sched.sv
// laser_fire_sched: frame-level scheduler for the laser repetition generator.
// Gates laser_enable to the scan frame bounded by motor zero pulses, converts
// send_en strobes into indexed fire pulses, stages the 240-bit offset pattern
// for atomic application at frame boundaries and detects a missing zero pulse.
// Optional per-frame statistics are enabled by defining FRAME_STAT_EN.
module laser_fire_sched #(
    parameter int unsigned  PULSE_NUM    = 811,
    parameter int unsigned  ZERO_TIMEOUT = 125_000_000,
    parameter logic [239:0] PRESDO_INIT  = 240'h000000000000111111111111222222222222333333333333444444444444
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scan_start,
    input  logic         zero_pulse,
    input  logic         send_en,
    output logic         laser_enable,
    output logic         fire,
    output logic [15:0]  pulse_idx,
    output logic         frame_done,
    output logic         frame_err,
    output logic         motor_fault,
    input  logic         cfg_wr,
    input  logic [2:0]   cfg_addr,
    input  logic [31:0]  cfg_data,
    input  logic         cfg_commit,
    output logic         cfg_pending,
    output logic [239:0] laser_presdo,
    output logic [15:0]  fire_cnt_last,
    output logic [15:0]  err_cnt
);

    // Timer is at least 27 bits so the default 1 s timeout at 125 MHz fits.
    localparam int unsigned   TW       = ($clog2(ZERO_TIMEOUT) > 27) ? $clog2(ZERO_TIMEOUT) : 27;
    localparam logic [15:0]   LAST_IDX = 16'(PULSE_NUM - 1);
    localparam logic [TW-1:0] TIMER_TC = TW'(ZERO_TIMEOUT - 1);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        WAIT_ZERO = 5'b00010,
        SCAN      = 5'b00100,
        HOLD      = 5'b01000,
        FAULT     = 5'b10000
    } state_t;

    state_t         state_r;
    logic [TW-1:0]  timer_r;
    logic [15:0]    frame_cnt_r;
    logic           laser_enable_r;
    logic           fire_r;
    logic [15:0]    pulse_idx_r;
    logic           frame_done_r;
    logic           frame_err_r;
    logic           motor_fault_r;
    logic           cfg_pending_r;
    logic [239:0]   staging_r;
    logic [239:0]   presdo_r;

    logic           boundary_s;
    logic           fire_s;
    logic           last_fire_s;
    logic           early_zero_s;
    logic           timeout_s;
    logic           apply_s;
    logic [TW-1:0]  timer_inc_s;
    logic [239:0]   staging_nxt_s;

    // Decode of frame events and the staging value including any same-cycle write.
    always_comb begin
        boundary_s   = scan_start && zero_pulse &&
                       ((state_r == WAIT_ZERO) || (state_r == SCAN) || (state_r == HOLD));
        fire_s       = scan_start && (state_r == SCAN) && send_en && !zero_pulse;
        last_fire_s  = fire_s && (frame_cnt_r == LAST_IDX);
        early_zero_s = boundary_s && (state_r == SCAN);
        timeout_s    = scan_start && !zero_pulse && (timer_r == TIMER_TC) &&
                       ((state_r == WAIT_ZERO) || (state_r == HOLD));
        // No frame runs in IDLE/FAULT, so a commit there applies immediately.
        apply_s      = (((state_r == IDLE) || (state_r == FAULT)) && (cfg_commit || cfg_pending_r)) ||
                       (boundary_s && (cfg_commit || cfg_pending_r));
        timer_inc_s  = (timer_r == TIMER_TC) ? timer_r : (timer_r + TW'(1));
        staging_nxt_s = staging_r;
        if (cfg_wr) begin
            case (cfg_addr)
                3'd0:    staging_nxt_s[31:0]    = cfg_data;
                3'd1:    staging_nxt_s[63:32]   = cfg_data;
                3'd2:    staging_nxt_s[95:64]   = cfg_data;
                3'd3:    staging_nxt_s[127:96]  = cfg_data;
                3'd4:    staging_nxt_s[159:128] = cfg_data;
                3'd5:    staging_nxt_s[191:160] = cfg_data;
                3'd6:    staging_nxt_s[223:192] = cfg_data;
                3'd7:    staging_nxt_s[239:224] = cfg_data[15:0];
                default: staging_nxt_s          = staging_r;
            endcase
        end else begin
            staging_nxt_s = staging_r;
        end
    end

    // Frame FSM with registered strobes, enable, index and zero-pulse timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            timer_r        <= '0;
            frame_cnt_r    <= 16'd0;
            laser_enable_r <= 1'b0;
            fire_r         <= 1'b0;
            pulse_idx_r    <= 16'd0;
            frame_done_r   <= 1'b0;
            frame_err_r    <= 1'b0;
            motor_fault_r  <= 1'b0;
        end else begin
            fire_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (!scan_start) begin
                // Host abort: silent return to IDLE, no fire and no frame_done.
                state_r        <= IDLE;
                laser_enable_r <= 1'b0;
                motor_fault_r  <= 1'b0;
                timer_r        <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= WAIT_ZERO;
                        timer_r <= '0;
                    end
                    WAIT_ZERO: begin
                        if (zero_pulse) begin
                            state_r        <= SCAN;
                            laser_enable_r <= 1'b1;
                            frame_cnt_r    <= 16'd0;
                            timer_r        <= '0;
                        end else if (timeout_s) begin
                            state_r        <= FAULT;
                            laser_enable_r <= 1'b0;
                            motor_fault_r  <= 1'b1;
                        end else begin
                            timer_r <= timer_inc_s;
                        end
                    end
                    SCAN: begin
                        if (zero_pulse) begin
                            // Early zero: close the short frame and start a new one.
                            frame_done_r <= 1'b1;
                            frame_err_r  <= 1'b1;
                            frame_cnt_r  <= 16'd0;
                            timer_r      <= '0;
                        end else begin
                            timer_r <= timer_inc_s;
                            if (fire_s) begin
                                fire_r      <= 1'b1;
                                pulse_idx_r <= frame_cnt_r;
                                frame_cnt_r <= frame_cnt_r + 16'd1;
                            end else begin
                                fire_r <= 1'b0;
                            end
                            if (last_fire_s) begin
                                frame_done_r   <= 1'b1;
                                laser_enable_r <= 1'b0;
                                state_r        <= HOLD;
                            end else begin
                                state_r <= SCAN;
                            end
                        end
                    end
                    HOLD: begin
                        laser_enable_r <= 1'b0;
                        if (zero_pulse) begin
                            state_r        <= SCAN;
                            laser_enable_r <= 1'b1;
                            frame_cnt_r    <= 16'd0;
                            timer_r        <= '0;
                        end else if (timeout_s) begin
                            state_r       <= FAULT;
                            motor_fault_r <= 1'b1;
                        end else begin
                            timer_r <= timer_inc_s;
                        end
                    end
                    FAULT: begin
                        laser_enable_r <= 1'b0;
                        motor_fault_r  <= 1'b1;
                    end
                    default: begin
                        state_r        <= IDLE;
                        laser_enable_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Offset pattern staging and atomic application at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_r     <= PRESDO_INIT;
            presdo_r      <= PRESDO_INIT;
            cfg_pending_r <= 1'b0;
        end else begin
            staging_r <= staging_nxt_s;
            if (apply_s) begin
                presdo_r      <= staging_nxt_s;
                cfg_pending_r <= 1'b0;
            end else if (cfg_commit) begin
                cfg_pending_r <= 1'b1;
            end else begin
                cfg_pending_r <= cfg_pending_r;
            end
        end
    end

`ifdef FRAME_STAT_EN
    logic [15:0] fire_cnt_last_r;
    logic [15:0] err_cnt_r;

    // Per-frame fire count capture and saturating error/fault counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_cnt_last_r <= 16'd0;
            err_cnt_r       <= 16'd0;
        end else begin
            if (last_fire_s) begin
                fire_cnt_last_r <= frame_cnt_r + 16'd1;
            end else if (early_zero_s) begin
                fire_cnt_last_r <= frame_cnt_r;
            end else begin
                fire_cnt_last_r <= fire_cnt_last_r;
            end
            if ((early_zero_s || timeout_s) && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign fire_cnt_last = fire_cnt_last_r;
    assign err_cnt       = err_cnt_r;
`else
    assign fire_cnt_last = 16'd0;
    assign err_cnt       = 16'd0;
`endif

    assign laser_enable = laser_enable_r;
    assign fire         = fire_r;
    assign pulse_idx    = pulse_idx_r;
    assign frame_done   = frame_done_r;
    assign frame_err    = frame_err_r;
    assign motor_fault  = motor_fault_r;
    assign cfg_pending  = cfg_pending_r;
    assign laser_presdo = presdo_r;

endmodule

// File: tb/tb_laser_fire_sched.sv
// Testbench for laser_fire_sched with PULSE_NUM=4 and ZERO_TIMEOUT=1000.
// Expected outputs come from a vector table pushed through a scoreboard queue,
// plus hand-written sequences for timeout, configuration and reset.
module tb_laser_fire_sched;

    localparam logic [239:0] INIT = 240'h000000000000111111111111222222222222333333333333444444444444;
`ifdef FRAME_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scan_start, zero_pulse, send_en;
    logic         laser_enable, fire, frame_done, frame_err, motor_fault;
    logic [15:0]  pulse_idx, fire_cnt_last, err_cnt;
    logic         cfg_wr, cfg_commit, cfg_pending;
    logic [2:0]   cfg_addr;
    logic [31:0]  cfg_data;
    logic [239:0] laser_presdo;

    int pass_cnt = 0;
    int total_cnt = 0;

    laser_fire_sched #(.PULSE_NUM(4), .ZERO_TIMEOUT(1000), .PRESDO_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .scan_start(scan_start), .zero_pulse(zero_pulse),
        .send_en(send_en), .laser_enable(laser_enable), .fire(fire), .pulse_idx(pulse_idx),
        .frame_done(frame_done), .frame_err(frame_err), .motor_fault(motor_fault),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .laser_presdo(laser_presdo),
        .fire_cnt_last(fire_cnt_last), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ss, z, s;
        logic        le, f;
        logic [15:0] idx;
        logic        d, e;
        logic [15:0] fcl, ec;
    } vec_t;

    vec_t tbl[15];
    vec_t exp_q[$];

    function automatic logic [15:0] st(input logic [15:0] v);
        return STAT ? v : 16'd0;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // One clock: apply inputs, sample outputs 1 time unit after the edge.
    task automatic drive(input logic ss, input logic z, input logic s);
        scan_start = ss; zero_pulse = z; send_en = s;
        @(posedge clk); #1;
        zero_pulse = 1'b0; send_en = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_le"}, 256'(laser_enable), 256'(1'b0));
        chk({tag, "_fire"}, 256'(fire), 256'(1'b0));
        chk({tag, "_idx"}, 256'(pulse_idx), 256'(16'd0));
        chk({tag, "_done"}, 256'(frame_done), 256'(1'b0));
        chk({tag, "_err"}, 256'(frame_err), 256'(1'b0));
        chk({tag, "_mf"}, 256'(motor_fault), 256'(1'b0));
        chk({tag, "_pend"}, 256'(cfg_pending), 256'(1'b0));
        chk({tag, "_presdo"}, 256'(laser_presdo), 256'(INIT));
        chk({tag, "_fcl"}, 256'(fire_cnt_last), 256'(16'd0));
        chk({tag, "_ec"}, 256'(err_cnt), 256'(16'd0));
    endtask

    initial begin
        logic [239:0] exp_p;
        vec_t         e;

        rst_n = 1'b0; scan_start = 1'b0; zero_pulse = 1'b0; send_en = 1'b0;
        cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_addr = 3'd0; cfg_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Full frame with 130-cycle send spacing; strobes 5 and 6 land in HOLD.
        drive(1'b1, 1'b0, 1'b0);
        chk("a_le_wait", 256'(laser_enable), 256'(1'b0));
        drive(1'b1, 1'b1, 1'b0);
        chk("a_le_scan", 256'(laser_enable), 256'(1'b1));
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk($sformatf("a_fire%0d", k), 256'(fire), 256'(k < 4));
            chk($sformatf("a_idx%0d", k), 256'(pulse_idx), 256'((k < 4) ? k : 3));
            chk($sformatf("a_done%0d", k), 256'(frame_done), 256'(k == 3));
            chk($sformatf("a_le%0d", k), 256'(laser_enable), 256'(k < 3));
            repeat (129) drive(1'b1, 1'b0, 1'b0);
        end
        chk("a_fcl", 256'(fire_cnt_last), 256'(st(16'd4)));
        drive(1'b0, 1'b0, 1'b0);

        // Vector table: short frame, HOLD, early zero with coincident send, abort.
        tbl[0]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,16'd3, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[1]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,16'd3, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[2]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd0, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[3]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,16'd0, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[4]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd1, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[5]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd2, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[6]  = '{1'b1,1'b0,1'b1, 1'b0,1'b1,16'd3, 1'b1,1'b0, st(16'd4),st(16'd0)};
        tbl[7]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,16'd3, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[8]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,16'd3, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[9]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd0, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[10] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd1, 1'b0,1'b0, st(16'd4),st(16'd0)};
        tbl[11] = '{1'b1,1'b1,1'b1, 1'b1,1'b0,16'd1, 1'b1,1'b1, st(16'd2),st(16'd1)};
        tbl[12] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,16'd0, 1'b0,1'b0, st(16'd2),st(16'd1)};
        tbl[13] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,16'd0, 1'b0,1'b0, st(16'd2),st(16'd1)};
        tbl[14] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,16'd0, 1'b0,1'b0, st(16'd2),st(16'd1)};
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(tbl[i]);
            drive(tbl[i].ss, tbl[i].z, tbl[i].s);
            e = exp_q.pop_front();
            chk($sformatf("t%0d_le", i), 256'(laser_enable), 256'(e.le));
            chk($sformatf("t%0d_fire", i), 256'(fire), 256'(e.f));
            chk($sformatf("t%0d_idx", i), 256'(pulse_idx), 256'(e.idx));
            chk($sformatf("t%0d_done", i), 256'(frame_done), 256'(e.d));
            chk($sformatf("t%0d_err", i), 256'(frame_err), 256'(e.e));
            chk($sformatf("t%0d_mf", i), 256'(motor_fault), 256'(1'b0));
            chk($sformatf("t%0d_fcl", i), 256'(fire_cnt_last), 256'(e.fcl));
            chk($sformatf("t%0d_ec", i), 256'(err_cnt), 256'(e.ec));
        end

        // Zero-pulse timeout: fault exactly 1000 cycles after entering WAIT_ZERO.
        drive(1'b1, 1'b0, 1'b0);
        repeat (999) drive(1'b1, 1'b0, 1'b0);
        chk("to_mf_early", 256'(motor_fault), 256'(1'b0));
        drive(1'b1, 1'b0, 1'b0);
        chk("to_mf", 256'(motor_fault), 256'(1'b1));
        chk("to_le", 256'(laser_enable), 256'(1'b0));
        chk("to_ec", 256'(err_cnt), 256'(st(16'd2)));
        drive(1'b1, 1'b0, 1'b0);
        chk("to_mf_held", 256'(motor_fault), 256'(1'b1));
        drive(1'b0, 1'b0, 1'b0);
        chk("to_mf_clear", 256'(motor_fault), 256'(1'b0));

        // Mid-frame staged write and commit applied at the next zero pulse.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 32'hDEADBEEF;
        drive(1'b1, 1'b0, 1'b0);
        cfg_wr = 1'b1; cfg_addr = 3'd7; cfg_data = 32'hFFFF1234;
        drive(1'b1, 1'b0, 1'b0);
        cfg_commit = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("cfg_pend", 256'(cfg_pending), 256'(1'b1));
        chk("cfg_hold0", 256'(laser_presdo), 256'(INIT));
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        chk("cfg_hold1", 256'(laser_presdo), 256'(INIT));
        drive(1'b1, 1'b1, 1'b0);
        exp_p = INIT;
        exp_p[31:0] = 32'hDEADBEEF;
        exp_p[239:224] = 16'h1234;
        chk("cfg_lo", 256'(laser_presdo[31:0]), 256'(32'hDEADBEEF));
        chk("cfg_hi", 256'(laser_presdo[239:224]), 256'(16'h1234));
        chk("cfg_all", 256'(laser_presdo), 256'(exp_p));
        chk("cfg_pend_clr", 256'(cfg_pending), 256'(1'b0));
        chk("cfg_le", 256'(laser_enable), 256'(1'b1));
        chk("cfg_ferr", 256'(frame_err), 256'(1'b1));
        chk("cfg_fcl", 256'(fire_cnt_last), 256'(st(16'd2)));
        chk("cfg_ec", 256'(err_cnt), 256'(st(16'd3)));

        // Commit in IDLE applies on the next cycle, with a same-cycle write.
        drive(1'b0, 1'b0, 1'b0);
        cfg_wr = 1'b1; cfg_addr = 3'd3; cfg_data = 32'h55AA55AA; cfg_commit = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        exp_p[127:96] = 32'h55AA55AA;
        chk("idle_apply", 256'(laser_presdo), 256'(exp_p));
        chk("idle_pend", 256'(cfg_pending), 256'(1'b0));

        // Asynchronous reset mid-SCAN, then restart through WAIT_ZERO.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        cfg_commit = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        chk("rs_pre_fire", 256'(fire), 256'(1'b1));
        chk("rs_pre_idx", 256'(pulse_idx), 256'(16'd1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("rs_wait_le", 256'(laser_enable), 256'(1'b0));
        drive(1'b1, 1'b1, 1'b0);
        chk("rs_scan_le", 256'(laser_enable), 256'(1'b1));
        chk("rs_presdo", 256'(laser_presdo), 256'(INIT));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
